// File: rtl/cp0_defs.sv
// Shared coprocessor-0 definitions for the interrupt responder.
// Holds the responder FSM encoding, the cp0 register addresses and the
// bit positions of the Status and Cause fields.
package cp0_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAKE = 2'd1,
    ST_ACK  = 2'd2,
    ST_SVC  = 2'd3
  } irq_state_e;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_EXL_BIT = 1;
  localparam int CAUSE_IP_BIT   = 10;
  localparam int CAUSE_CNT_LSB  = 16;
  localparam int CAUSE_CNT_W    = 16;

endpackage

// File: rtl/int_responder.sv
// Single-source interrupt responder with a minimal cp0 register file.
// Takes a level interrupt at an instruction boundary, redirects the PC to
// VECTOR, runs a four-phase Ireq/Iack handshake and returns to EPC on eret.
//
// Ports:
//   Clk_CPU, rst          clock, async active-high reset
//   Enable_i              CPU step enable; all state holds while low
//   Ireq / Iack           request level in, registered acknowledge out
//   inst_done, pc_next    instruction boundary and resume address
//   eret_i                return-from-exception executing
//   cp0_we/addr/wdata     cp0 register write; cp0_rdata combinational read
//   int_redirect          PC override strobe, redirect_pc its target
//   in_service            EXL; irq_count number of interrupts taken
module int_responder
  import cp0_defs::*;
#(
  parameter logic [31:0] VECTOR = 32'h0000_0004,
  parameter int          CNT_W  = 16
) (
  input  logic             Clk_CPU,
  input  logic             rst,
  input  logic             Enable_i,
  input  logic             Ireq,
  output logic             Iack,
  input  logic             inst_done,
  input  logic [31:0]      pc_next,
  input  logic             eret_i,
  input  logic             cp0_we,
  input  logic [4:0]       cp0_addr,
  input  logic [31:0]      cp0_wdata,
  output logic [31:0]      cp0_rdata,
  output logic             int_redirect,
  output logic [31:0]      redirect_pc,
  output logic             in_service,
  output logic [CNT_W-1:0] irq_count
);

  irq_state_e       state_q, state_d;
  logic             iack_q, iack_d;
  logic             redirect_q, redirect_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             ie_q, ie_d;
  logic             exl_q, exl_d;
  logic [31:0]      epc_q, epc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             take;
  logic             eret_go;

  // Decisions use register values from before this cycle's cp0 write,
  // so a same-cycle Status write only affects later boundaries.
  assign take    = (state_q == ST_IDLE) && Ireq && ie_q && inst_done;
  assign eret_go = (state_q == ST_SVC) && eret_i && inst_done;

  always_comb begin
    state_d       = state_q;
    iack_d        = iack_q;
    redirect_d    = redirect_q;
    redirect_pc_d = redirect_pc_q;
    ie_d          = ie_q;
    exl_d         = exl_q;
    epc_d         = epc_q;
    cnt_d         = cnt_q;

    if (Enable_i) begin
      redirect_d = 1'b0;

      // Software writes first; hardware updates below override them.
      if (cp0_we && cp0_addr == CP0_STATUS) ie_d  = cp0_wdata[STATUS_IE_BIT];
      if (cp0_we && cp0_addr == CP0_EPC && !eret_go) epc_d = cp0_wdata;

      unique case (state_q)
        ST_IDLE: begin
          if (take) begin
            state_d       = ST_TAKE;
            iack_d        = 1'b1;
            exl_d         = 1'b1;
            epc_d         = pc_next;
            redirect_d    = 1'b1;
            redirect_pc_d = VECTOR;
            cnt_d         = cnt_q + CNT_W'(1);
          end
        end
        ST_TAKE: state_d = ST_ACK;
        ST_ACK: begin
          // Requester drops Ireq after seeing Iack; we then release Iack.
          if (!Ireq) begin
            state_d = ST_SVC;
            iack_d  = 1'b0;
          end
        end
        ST_SVC: begin
          if (eret_go) begin
            state_d       = ST_IDLE;
            exl_d         = 1'b0;
            redirect_d    = 1'b1;
            redirect_pc_d = epc_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk_CPU or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      iack_q        <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      ie_q          <= 1'b0;
      exl_q         <= 1'b0;
      epc_q         <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      iack_q        <= iack_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      ie_q          <= ie_d;
      exl_q         <= exl_d;
      epc_q         <= epc_d;
      cnt_q         <= cnt_d;
    end
  end

  // Widen then slice so the Cause count field is zero-extended or
  // truncated to 16 bits for any CNT_W.
  logic [CNT_W+CAUSE_CNT_W-1:0] cnt_wide;
  assign cnt_wide = {{CAUSE_CNT_W{1'b0}}, cnt_q};

  always_comb begin
    cp0_rdata = '0;
    unique case (cp0_addr)
      CP0_STATUS: begin
        cp0_rdata[STATUS_IE_BIT]  = ie_q;
        cp0_rdata[STATUS_EXL_BIT] = exl_q;
      end
      CP0_CAUSE: begin
        cp0_rdata[CAUSE_IP_BIT]                      = Ireq;
        cp0_rdata[CAUSE_CNT_LSB +: CAUSE_CNT_W]      = cnt_wide[CAUSE_CNT_W-1:0];
      end
      CP0_EPC: cp0_rdata = epc_q;
      default: cp0_rdata = '0;
    endcase
  end

  assign Iack         = iack_q;
  assign int_redirect = redirect_q;
  assign redirect_pc  = redirect_pc_q;
  assign in_service   = exl_q;
  assign irq_count    = cnt_q;

endmodule

// File: tb/tb_int_responder.sv
// Directed bench for int_responder. Uses a 4-bit counter instance so the
// counter wrap is reachable in a short run.
module tb_int_responder;

  localparam int CW = 4;

  logic          Clk_CPU = 1'b0;
  logic          rst, Enable_i, Ireq, inst_done, eret_i, cp0_we;
  logic [31:0]   pc_next, cp0_wdata;
  logic [4:0]    cp0_addr;
  logic          Iack, int_redirect, in_service;
  logic [31:0]   cp0_rdata, redirect_pc;
  logic [CW-1:0] irq_count;

  int n_chk  = 0;
  int n_fail = 0;

  int_responder #(.VECTOR(32'h0000_0004), .CNT_W(CW)) dut (
    .Clk_CPU(Clk_CPU), .rst(rst), .Enable_i(Enable_i), .Ireq(Ireq), .Iack(Iack),
    .inst_done(inst_done), .pc_next(pc_next), .eret_i(eret_i),
    .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
    .int_redirect(int_redirect), .redirect_pc(redirect_pc),
    .in_service(in_service), .irq_count(irq_count)
  );

  always #5 Clk_CPU = ~Clk_CPU;

  task automatic step();
    @(posedge Clk_CPU);
    #1;
  endtask

  task automatic rd(input logic [4:0] a);
    cp0_addr = a;
    #1;
  endtask

  // Drives one complete take / handshake / eret sequence from IDLE.
  task automatic full_take(input logic [31:0] pc);
    pc_next = pc; Ireq = 1'b1; inst_done = 1'b1; eret_i = 1'b0;
    step();
    step();
    Ireq = 1'b0;
    step();
    eret_i = 1'b1;
    step();
    eret_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; Enable_i = 1'b1; Ireq = 1'b0; inst_done = 1'b0; eret_i = 1'b0;
    cp0_we = 1'b0; cp0_addr = 5'd0; cp0_wdata = 32'h0; pc_next = 32'h0;
    #12;
    n_chk++; if (Iack !== 1'b0) begin n_fail++; $display("FAIL reset_iack: got %b want 0", Iack); end
    n_chk++; if (int_redirect !== 1'b0) begin n_fail++; $display("FAIL reset_redir: got %b want 0", int_redirect); end
    n_chk++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_rpc: got %h want 0", redirect_pc); end
    n_chk++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL reset_exl: got %b want 0", in_service); end
    n_chk++; if (irq_count !== 4'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", irq_count); end
    rd(5'd12);
    n_chk++; if (cp0_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h want 0", cp0_rdata); end
    rd(5'd14);
    n_chk++; if (cp0_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_epc: got %h want 0", cp0_rdata); end
    @(negedge Clk_CPU);
    rst = 1'b0;
    step();
  endtask

  task automatic test_take();
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h1;
    step();
    cp0_we = 1'b0;
    rd(5'd12);
    n_chk++; if (cp0_rdata !== 32'h1) begin n_fail++; $display("FAIL status_ie_write: got %h want 1", cp0_rdata); end
    pc_next = 32'h40; Ireq = 1'b1; inst_done = 1'b1; Enable_i = 1'b0;
    step();
    n_chk++; if (Iack !== 1'b0) begin n_fail++; $display("FAIL enable_gate: got %b want 0", Iack); end
    Enable_i = 1'b1;
    step();
    n_chk++; if (Iack !== 1'b1) begin n_fail++; $display("FAIL take_iack: got %b want 1", Iack); end
    n_chk++; if (int_redirect !== 1'b1) begin n_fail++; $display("FAIL take_redir: got %b want 1", int_redirect); end
    n_chk++; if (redirect_pc !== 32'h4) begin n_fail++; $display("FAIL take_rpc: got %h want 4", redirect_pc); end
    n_chk++; if (irq_count !== 4'h1) begin n_fail++; $display("FAIL take_cnt: got %h want 1", irq_count); end
    rd(5'd14);
    n_chk++; if (cp0_rdata !== 32'h40) begin n_fail++; $display("FAIL take_epc: got %h want 40", cp0_rdata); end
    rd(5'd12);
    n_chk++; if (cp0_rdata !== 32'h3) begin n_fail++; $display("FAIL take_status: got %h want 3", cp0_rdata); end
    inst_done = 1'b0;
    step();
    n_chk++; if (int_redirect !== 1'b0) begin n_fail++; $display("FAIL ack_redir: got %b want 0", int_redirect); end
    n_chk++; if (Iack !== 1'b1) begin n_fail++; $display("FAIL ack_iack: got %b want 1", Iack); end
    eret_i = 1'b1; inst_done = 1'b1;
    step();
    n_chk++; if (in_service !== 1'b1) begin n_fail++; $display("FAIL eret_in_ack: got %b want 1", in_service); end
    n_chk++; if (int_redirect !== 1'b0) begin n_fail++; $display("FAIL eret_in_ack_redir: got %b want 0", int_redirect); end
    eret_i = 1'b0; Ireq = 1'b0;
    step();
    n_chk++; if (Iack !== 1'b0) begin n_fail++; $display("FAIL svc_iack: got %b want 0", Iack); end
    n_chk++; if (in_service !== 1'b1) begin n_fail++; $display("FAIL svc_exl: got %b want 1", in_service); end
  endtask

  task automatic test_nesting();
    Ireq = 1'b1; inst_done = 1'b1;
    repeat (3) step();
    n_chk++; if (Iack !== 1'b0) begin n_fail++; $display("FAIL nest_iack: got %b want 0", Iack); end
    n_chk++; if (int_redirect !== 1'b0) begin n_fail++; $display("FAIL nest_redir: got %b want 0", int_redirect); end
    pc_next = 32'h80; eret_i = 1'b1;
    step();
    n_chk++; if (int_redirect !== 1'b1) begin n_fail++; $display("FAIL eret_redir: got %b want 1", int_redirect); end
    n_chk++; if (redirect_pc !== 32'h40) begin n_fail++; $display("FAIL eret_rpc: got %h want 40", redirect_pc); end
    n_chk++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL eret_exl: got %b want 0", in_service); end
    n_chk++; if (Iack !== 1'b0) begin n_fail++; $display("FAIL eret_iack: got %b want 0", Iack); end
    eret_i = 1'b0;
    step();
    n_chk++; if (Iack !== 1'b1) begin n_fail++; $display("FAIL take2_iack: got %b want 1", Iack); end
    n_chk++; if (irq_count !== 4'h2) begin n_fail++; $display("FAIL take2_cnt: got %h want 2", irq_count); end
    rd(5'd14);
    n_chk++; if (cp0_rdata !== 32'h80) begin n_fail++; $display("FAIL take2_epc: got %h want 80", cp0_rdata); end
    step();
    Ireq = 1'b0;
    step();
    eret_i = 1'b1;
    step();
    eret_i = 1'b0;
    n_chk++; if (redirect_pc !== 32'h80) begin n_fail++; $display("FAIL eret2_rpc: got %h want 80", redirect_pc); end
  endtask

  task automatic test_collision();
    pc_next = 32'h100; Ireq = 1'b1; inst_done = 1'b1;
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0;
    step();
    cp0_we = 1'b0;
    n_chk++; if (Iack !== 1'b1) begin n_fail++; $display("FAIL pre_write_ie_take: got %b want 1", Iack); end
    n_chk++; if (irq_count !== 4'h3) begin n_fail++; $display("FAIL take3_cnt: got %h want 3", irq_count); end
    rd(5'd12);
    n_chk++; if (cp0_rdata !== 32'h2) begin n_fail++; $display("FAIL ie_cleared: got %h want 2", cp0_rdata); end
    step();
    Ireq = 1'b0;
    step();
    cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h200;
    step();
    cp0_we = 1'b0;
    rd(5'd14);
    n_chk++; if (cp0_rdata !== 32'h200) begin n_fail++; $display("FAIL epc_sw_write: got %h want 200", cp0_rdata); end
    eret_i = 1'b1;
    step();
    eret_i = 1'b0;
    n_chk++; if (redirect_pc !== 32'h200) begin n_fail++; $display("FAIL eret_sw_epc: got %h want 200", redirect_pc); end
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h1;
    step();
    pc_next = 32'h300; Ireq = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'hDEAD;
    step();
    cp0_we = 1'b0;
    rd(5'd14);
    n_chk++; if (cp0_rdata !== 32'h300) begin n_fail++; $display("FAIL epc_take_wins: got %h want 300", cp0_rdata); end
    n_chk++; if (irq_count !== 4'h4) begin n_fail++; $display("FAIL take4_cnt: got %h want 4", irq_count); end
    step();
    Ireq = 1'b0;
    step();
    eret_i = 1'b1;
    step();
    eret_i = 1'b0;
  endtask

  task automatic test_no_pending();
    Ireq = 1'b1; inst_done = 1'b0;
    step();
    rd(5'd13);
    n_chk++; if (cp0_rdata !== 32'h0004_0400) begin n_fail++; $display("FAIL cause_live: got %h want 00040400", cp0_rdata); end
    n_chk++; if (Iack !== 1'b0) begin n_fail++; $display("FAIL no_boundary: got %b want 0", Iack); end
    Ireq = 1'b0; inst_done = 1'b1;
    step();
    n_chk++; if (Iack !== 1'b0) begin n_fail++; $display("FAIL no_pending_iack: got %b want 0", Iack); end
    n_chk++; if (int_redirect !== 1'b0) begin n_fail++; $display("FAIL no_pending_redir: got %b want 0", int_redirect); end
    rd(5'd13);
    n_chk++; if (cp0_rdata !== 32'h0004_0000) begin n_fail++; $display("FAIL cause_idle: got %h want 00040000", cp0_rdata); end
    rd(5'd5);
    n_chk++; if (cp0_rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_addr: got %h want 0", cp0_rdata); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 11; i++) full_take(32'h500);
    n_chk++; if (irq_count !== 4'hF) begin n_fail++; $display("FAIL cnt_max: got %h want f", irq_count); end
    rd(5'd13);
    n_chk++; if (cp0_rdata !== 32'h000F_0000) begin n_fail++; $display("FAIL cause_max: got %h want 000f0000", cp0_rdata); end
    full_take(32'h600);
    n_chk++; if (irq_count !== 4'h0) begin n_fail++; $display("FAIL cnt_wrap: got %h want 0", irq_count); end
  endtask

  task automatic test_reset_mid();
    pc_next = 32'h40; Ireq = 1'b1; inst_done = 1'b1;
    step();
    step();
    n_chk++; if (Iack !== 1'b1) begin n_fail++; $display("FAIL mid_pre_iack: got %b want 1", Iack); end
    #2;
    rst = 1'b1;
    #1;
    n_chk++; if (Iack !== 1'b0) begin n_fail++; $display("FAIL async_rst_iack: got %b want 0", Iack); end
    n_chk++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL async_rst_exl: got %b want 0", in_service); end
    rd(5'd12);
    n_chk++; if (cp0_rdata !== 32'h0) begin n_fail++; $display("FAIL async_rst_status: got %h want 0", cp0_rdata); end
    rd(5'd14);
    n_chk++; if (cp0_rdata !== 32'h0) begin n_fail++; $display("FAIL async_rst_epc: got %h want 0", cp0_rdata); end
    Ireq = 1'b0;
    @(negedge Clk_CPU);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_take();
    test_nesting();
    test_collision();
    test_no_pending();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
